// File: rtl/sc_game_controller_pkg.sv
// sc_game_controller_pkg: shared state encoding and width helper for the game controller
package sc_game_controller_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_PLAY    = 3'd2,
    S_HIT     = 3'd3,
    S_NEST    = 3'd4,
    S_LEVELUP = 3'd5,
    S_OVER    = 3'd6,
    S_DONE    = 3'd7
  } state_e;
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sc_game_controller_edge.sv
// cc_edge_detect: sample + delay register producing a one-cycle rise or fall event
module cc_edge_detect #(
  parameter logic RST_VAL = 1'b0,
  parameter bit   FALL    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic evt
);
  logic samp_q, dly_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= RST_VAL;
      dly_q  <= RST_VAL;
    end else begin
      samp_q <= din;
      dly_q  <= samp_q;
    end
  end
  assign evt = FALL ? (~samp_q & dly_q) : (samp_q & ~dly_q);
endmodule

// File: rtl/sc_game_controller.sv
// sc_game_controller: game-flow FSM turning comparator flags into lives/level/run control
module sc_game_controller
  import sc_game_controller_pkg::*;
#(
  parameter int LIVES_INIT  = 3,
  parameter int LEVELS      = 4,
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic                                SC_GAMECTRL_CLOCK_50,
  input  logic                                SC_GAMECTRL_RESET_InLow,
  input  logic                                SC_GAMECTRL_Start_InLow,
  input  logic                                SC_GAMECTRL_Lose_InHigh,
  input  logic                                SC_GAMECTRL_WinL_InHigh,
  input  logic                                SC_GAMECTRL_Nest_InHigh,
  output logic                                SC_GAMECTRL_FrogClear_OutHigh,
  output logic                                SC_GAMECTRL_BackLoad_OutHigh,
  output logic                                SC_GAMECTRL_Run_OutHigh,
  output logic [width_of(LEVELS)-1:0]         SC_GAMECTRL_Level_Out,
  output logic [width_of(LIVES_INIT+1)-1:0]   SC_GAMECTRL_Lives_Out,
  output logic [2:0]                          SC_GAMECTRL_State_Out
);
  localparam int LIVES_W = width_of(LIVES_INIT + 1);
  localparam int LEVEL_W = width_of(LEVELS);
  localparam int CNT_W   = width_of(HOLD_CYCLES);
  localparam logic [LIVES_W-1:0] LIVES_FULL = LIVES_W'(LIVES_INIT);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(LEVELS - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(HOLD_CYCLES - 1);

  logic clk, rst_n;
  assign clk   = SC_GAMECTRL_CLOCK_50;
  assign rst_n = SC_GAMECTRL_RESET_InLow;

  logic ev_start, ev_lose, ev_win, ev_nest;
  cc_edge_detect #(.RST_VAL(1'b1), .FALL(1'b1)) u_start (.clk(clk), .rst_n(rst_n), .din(SC_GAMECTRL_Start_InLow), .evt(ev_start));
  cc_edge_detect #(.RST_VAL(1'b0), .FALL(1'b0)) u_lose  (.clk(clk), .rst_n(rst_n), .din(SC_GAMECTRL_Lose_InHigh), .evt(ev_lose));
  cc_edge_detect #(.RST_VAL(1'b0), .FALL(1'b0)) u_win   (.clk(clk), .rst_n(rst_n), .din(SC_GAMECTRL_WinL_InHigh), .evt(ev_win));
  cc_edge_detect #(.RST_VAL(1'b0), .FALL(1'b0)) u_nest  (.clk(clk), .rst_n(rst_n), .din(SC_GAMECTRL_Nest_InHigh), .evt(ev_nest));

  state_e             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               run_q, run_d, fc_q, fc_d, bl_q, bl_d;
  logic               hold_done;

  assign hold_done = cnt_q == CNT_MAX;

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    case (state_q)
      S_IDLE:    if (ev_start) state_d = S_LOAD;
      S_LOAD:    state_d = S_PLAY;
      S_PLAY: begin
        if (ev_lose) begin
          state_d = S_HIT;
          lives_d = (lives_q == '0) ? lives_q : lives_q - 1'b1;
        end else if (ev_nest) begin
          state_d = S_NEST;
        end else if (ev_win) begin
          state_d = S_LEVELUP;
        end
      end
      S_HIT:     state_d = (lives_q == '0) ? S_OVER : hold_done ? S_PLAY : S_HIT;
      S_NEST:    state_d = hold_done ? S_PLAY : S_NEST;
      S_LEVELUP: begin
        if (hold_done) begin
          state_d = (level_q == LEVEL_MAX) ? S_DONE : S_LOAD;
          level_d = (level_q == LEVEL_MAX) ? level_q : level_q + 1'b1;
        end
      end
      S_OVER, S_DONE: begin
        if (ev_start) begin
          state_d = S_LOAD;
          lives_d = LIVES_FULL;
          level_d = '0;
        end
      end
      default:   state_d = S_IDLE;
    endcase
    // pulses and run are decoded from the next state so they line up with State_Out
    run_d = state_d == S_PLAY;
    bl_d  = state_d == S_LOAD;
    fc_d  = (state_d == S_LOAD) || (state_d == S_PLAY && (state_q == S_HIT || state_q == S_NEST));
    cnt_d = (state_d != state_q) ? '0 : hold_done ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lives_q <= LIVES_FULL;
      level_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      fc_q    <= 1'b0;
      bl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      fc_q    <= fc_d;
      bl_q    <= bl_d;
    end
  end

  assign SC_GAMECTRL_FrogClear_OutHigh = fc_q;
  assign SC_GAMECTRL_BackLoad_OutHigh  = bl_q;
  assign SC_GAMECTRL_Run_OutHigh       = run_q;
  assign SC_GAMECTRL_Level_Out         = level_q;
  assign SC_GAMECTRL_Lives_Out         = lives_q;
  assign SC_GAMECTRL_State_Out         = state_q;
endmodule

// File: tb/tb_sc_game_controller.sv
// tb_sc_game_controller: randomized game sessions checked by a scoreboard of expected state entries
module tb_sc_game_controller;
  localparam int HOLD = 4, LIVES = 3, LEVELS = 4;
  localparam int IDLE = 0, LOAD = 1, PLAY = 2, HIT = 3, NEST = 4, LEVELUP = 5, OVER = 6, DONE = 7;

  logic clk = 1'b0, rst_n = 1'b0, start_n = 1'b1, lose = 1'b0, winl = 1'b0, nest = 1'b0;
  logic fc, bl, run;
  logic [1:0] level, lives;
  logic [2:0] st;

  sc_game_controller #(.LIVES_INIT(LIVES), .LEVELS(LEVELS), .HOLD_CYCLES(HOLD)) dut (
    .SC_GAMECTRL_CLOCK_50(clk),
    .SC_GAMECTRL_RESET_InLow(rst_n),
    .SC_GAMECTRL_Start_InLow(start_n),
    .SC_GAMECTRL_Lose_InHigh(lose),
    .SC_GAMECTRL_WinL_InHigh(winl),
    .SC_GAMECTRL_Nest_InHigh(nest),
    .SC_GAMECTRL_FrogClear_OutHigh(fc),
    .SC_GAMECTRL_BackLoad_OutHigh(bl),
    .SC_GAMECTRL_Run_OutHigh(run),
    .SC_GAMECTRL_Level_Out(level),
    .SC_GAMECTRL_Lives_Out(lives),
    .SC_GAMECTRL_State_Out(st)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int lives;
    int level;
    int run;
    int fc;
    int bl;
    int dwell;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;
  bit mon_en = 1'b0;
  int m_state = IDLE, m_lives = LIVES, m_level = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic void push(input int s, input int l, input int v, input int r, input int f, input int b, input int d);
    q.push_back('{s, l, v, r, f, b, d});
  endfunction

  // monitor: every state change is one DUT output transaction
  initial begin
    int prev, dwell;
    bit have;
    exp_t cur, e;
    prev = 0; dwell = 0; have = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!mon_en) begin
        prev = int'(st); dwell = 0; have = 1'b0;
        continue;
      end
      if (int'(st) != prev) begin
        if (have && cur.dwell != 0) chk("dwell", dwell, cur.dwell);
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_state actual=%0d expected=none", st);
          have = 1'b0;
        end else begin
          e = q.pop_front();
          chk("state", int'(st), e.st);
          chk("lives", int'(lives), e.lives);
          chk("level", int'(level), e.level);
          chk("run", int'(run), e.run);
          chk("frogclear", int'(fc), e.fc);
          chk("backload", int'(bl), e.bl);
          cur = e; have = 1'b1;
        end
        prev = int'(st); dwell = 1;
      end else begin
        dwell++;
        chk("frogclear_idle", int'(fc), 0);
        chk("backload_idle", int'(bl), 0);
      end
    end
  end

  task automatic press_start();
    if (m_state == IDLE || m_state == OVER || m_state == DONE) begin
      m_lives = LIVES; m_level = 0; m_state = PLAY;
      push(LOAD, LIVES, 0, 0, 1, 1, 1);
      push(PLAY, LIVES, 0, 1, 0, 0, 0);
    end
    @(negedge clk) start_n = 1'b0;
    @(negedge clk) start_n = 1'b1;
  endtask

  task automatic play_event(input bit l, input bit n, input bit w);
    if (l) begin
      m_lives--;
      push(HIT, m_lives, m_level, 0, 0, 0, (m_lives == 0) ? 1 : HOLD);
      if (m_lives == 0) begin
        push(OVER, 0, m_level, 0, 0, 0, 0); m_state = OVER;
      end else push(PLAY, m_lives, m_level, 1, 1, 0, 0);
    end else if (n) begin
      push(NEST, m_lives, m_level, 0, 0, 0, HOLD);
      push(PLAY, m_lives, m_level, 1, 1, 0, 0);
    end else if (w) begin
      push(LEVELUP, m_lives, m_level, 0, 0, 0, HOLD);
      if (m_level == LEVELS - 1) begin
        push(DONE, m_lives, m_level, 0, 0, 0, 0); m_state = DONE;
      end else begin
        m_level++;
        push(LOAD, m_lives, m_level, 0, 1, 1, 1);
        push(PLAY, m_lives, m_level, 1, 0, 0, 0);
      end
    end
    @(negedge clk);
    lose = l; nest = n; winl = w;
    repeat ($urandom_range(1, 10)) @(negedge clk);
    lose = 1'b0; nest = 1'b0; winl = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int r;
    repeat (3) @(negedge clk);
    chk("rst_state", int'(st), IDLE);
    chk("rst_run", int'(run), 0);
    chk("rst_lives", int'(lives), LIVES);
    chk("rst_level", int'(level), 0);
    chk("rst_fc", int'(fc), 0);
    chk("rst_bl", int'(bl), 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    for (int it = 0; it < 80; it++) begin
      if (m_state != PLAY) begin
        if ($urandom_range(0, 2) == 0) begin
          lose = 1'b1; winl = 1'b1;
          repeat (2) @(negedge clk);
          lose = 1'b0; winl = 1'b0;
          repeat (2) @(negedge clk);
        end
        press_start();
      end else begin
        r = $urandom_range(0, 6);
        case (r)
          0:       play_event(1'b1, 1'b0, 1'b0);
          1:       play_event(1'b0, 1'b1, 1'b0);
          2, 3:    play_event(1'b0, 1'b0, 1'b1);
          4:       play_event(1'b1, 1'b1, 1'b1);
          5:       play_event(1'b0, 1'b1, 1'b1);
          default: press_start();
        endcase
      end
      drain();
    end
    if (m_state != PLAY) begin
      press_start();
      drain();
    end
    mon_en = 1'b0;
    @(negedge clk) nest = 1'b1;
    @(negedge clk) nest = 1'b0;
    for (int i = 0; i < 20 && int'(st) != NEST; i++) @(negedge clk);
    chk("nest_entered", int'(st), NEST);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midhold_state", int'(st), IDLE);
    chk("midhold_run", int'(run), 0);
    chk("midhold_lives", int'(lives), LIVES);
    chk("midhold_level", int'(level), 0);
    chk("midhold_fc", int'(fc), 0);
    repeat (2) begin
      @(negedge clk);
      chk("midhold_fc_held", int'(fc), 0);
    end
    rst_n = 1'b1;
    q.delete();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
